sram_dp_clear: RTL

SRAM_DP_CLEAR -- requirements
Module: sram_dp_clear

---
 rtl/sram_dp_clear.sv | 103 ++++++++++
 1 files changed

// File: rtl/sram_dp_clear.sv
`timescale 1ns/1ps
// Dual-port SRAM (A: read/write with byte lanes, B: read-only) with a whole-array fill engine.
// Reads are registered (1 cycle); while the fill runs, port A writes are dropped and both read registers hold.
module sram_dp_clear #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 10,
   parameter int LANE_WIDTH = 8,
   parameter int RDW_MODE   = 0,
   parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             clear_req,
   output logic                             busy,
   input  logic [ADDR_WIDTH-1:0]            A_ADDR,
   input  logic [DATA_WIDTH-1:0]            A_DATA,
   input  logic                             A_CEn,
   input  logic                             A_OEn,
   input  logic                             A_WEn,
   input  logic [DATA_WIDTH/LANE_WIDTH-1:0] A_BEn,
   output logic [DATA_WIDTH-1:0]            A_Q,
   input  logic [ADDR_WIDTH-1:0]            B_ADDR,
   input  logic                             B_CEn,
   output logic [DATA_WIDTH-1:0]            B_Q
);
   localparam int NL = DATA_WIDTH / LANE_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t                  state, state_nxt;
   logic [ADDR_WIDTH-1:0]   cnt, cnt_nxt;
   logic [DATA_WIDTH-1:0]   mem [0:(1<<ADDR_WIDTH)-1];
   logic [DATA_WIDTH-1:0]   a_old, b_old, a_merged, a_rd_word, b_rd_word;
   logic                    a_wr, a_rd, b_rd;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= CLEAR;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // clear_req is only looked at in IDLE, so a request during a fill has no effect.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      busy      = 1'b0;
      case (state)
         IDLE: begin
            if (clear_req) begin
               state_nxt = CLEAR;
               cnt_nxt   = '0;
            end
         end
         CLEAR: begin
            busy = 1'b1;
            if (cnt == LAST_ADDR) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign a_old = mem[A_ADDR];
   assign b_old = mem[B_ADDR];
   assign a_wr  = !busy && !A_CEn && !A_WEn;
   assign a_rd  = !busy && !A_CEn && !A_OEn;
   assign b_rd  = !busy && !B_CEn;

   always_comb begin
      a_merged = a_old;
      for (int i = 0; i < NL; i++) begin
         if (!A_BEn[i]) a_merged[i*LANE_WIDTH +: LANE_WIDTH] = A_DATA[i*LANE_WIDTH +: LANE_WIDTH];
      end
   end

   // New-data mode forwards the merged word so unwritten lanes still show old contents.
   assign a_rd_word = (RDW_MODE == 1 && a_wr) ? a_merged : a_old;
   assign b_rd_word = (RDW_MODE == 1 && a_wr && B_ADDR == A_ADDR) ? a_merged : b_old;

   always_ff @(posedge clk) begin
      if (busy)      mem[cnt]    <= CLEAR_VALUE;
      else if (a_wr) mem[A_ADDR] <= a_merged;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         A_Q <= '0;
         B_Q <= '0;
      end else begin
         if (a_rd) A_Q <= a_rd_word;
         if (b_rd) B_Q <= b_rd_word;
      end
   end
endmodule
